// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared op codes, FSM state encoding and default width for the
//           multi-cycle multiply/divide sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int MULDIV_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module  : muldiv_step
// Brief   : One radix-2 iteration on {acc, q}: shift-add for multiply,
//           restoring subtract-compare-shift for divide.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
    shifted  = {acc, q[WIDTH-1]};
    ge       = (shifted >= {1'b0, m});
    // partial remainder stays below m, so the low WIDTH bits hold the exact difference
    diff     = shifted[WIDTH-1:0] - m;
    acc_next = sum[WIDTH:1];
    q_next   = {sum[0], q[WIDTH-1:1]};
    if (is_div) begin
      acc_next = ge ? diff : shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], ge};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module  : muldiv_sequencer
// Brief   : Multi-cycle MULT/MULTU/DIV/DIVU engine with HI/LO registers.
//           Optional macro MULDIV_DIVZERO_EN: fast divide-by-zero path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc, q, m, acc_next, q_next;
  logic             is_div, neg_a, neg_b, dz;
  logic             accept, write_mt, dz_skip;
  logic             is_muldiv_op, is_signed_op, is_div_op;
  logic [WIDTH-1:0] mag_x, mag_y;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign is_div_op    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_muldiv_op = is_signed_op || is_div_op || (op == OP_MULTU);
  assign mag_x        = (is_signed_op && x[WIDTH-1]) ? -x : x;
  assign mag_y        = (is_signed_op && y[WIDTH-1]) ? -y : y;

`ifdef MULDIV_DIVZERO_EN
  assign dz_skip = is_div_op && (y == '0);
`else
  assign dz_skip = 1'b0;
`endif

  assign busy     = (state != S_IDLE);
  assign prod     = {acc, q};
  assign prod_fix = (neg_a ^ neg_b) ? -prod : prod;
  assign quo_fix  = (neg_a ^ neg_b) ? -q : q;
  assign rem_fix  = neg_a ? -acc : acc;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    write_mt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !flush) begin
          if (is_muldiv_op) begin
            accept     = 1'b1;
            state_next = dz_skip ? S_FIX : S_CALC;
          end else if ((op == OP_MTHI) || (op == OP_MTLO)) begin
            write_mt = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (flush)              state_next = S_IDLE;
        else if (count == '0)   state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (accept) begin
        is_div <= is_div_op;
        neg_a  <= is_signed_op & x[WIDTH-1];
        neg_b  <= is_signed_op & y[WIDTH-1];
        dz     <= dz_skip;
        acc    <= '0;
        count  <= CNT_W'(WIDTH - 1);
        m      <= is_div_op ? mag_y : mag_x;
        // divide-by-zero shortcut keeps raw x in q so it can be written to hi
        q      <= dz_skip ? x : (is_div_op ? mag_x : mag_y);
      end else if (state == S_CALC) begin
        acc <= acc_next;
        q   <= q_next;
        if (count != '0) count <= count - 1'b1;
      end
      if (write_mt) begin
        if (op == OP_MTHI) hi <= x;
        else               lo <= x;
      end
      if ((state == S_FIX) && !flush) begin
        done     <= 1'b1;
        div_zero <= dz;
        if (dz) begin
          hi <= q;
          lo <= '1;
        end else if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module  : tb_muldiv_sequencer
// Brief   : Directed self-checking bench for muldiv_sequencer (honours
//           MULDIV_DIVZERO_EN when defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int busy_cnt, done_cnt, done_at;
  logic dz_seen;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .x        (x),
    .y        (y),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, then watch ncyc falling edges while scrambling operands.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int ncyc);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    busy_cnt = 0; done_cnt = 0; done_at = -1; dz_seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      start = 1'b0;
      x = $urandom;
      y = $urandom;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
        dz_seen = div_zero;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    rst = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 40);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_busy_cycles", 64'(busy_cnt), 64'd33);
    check("mult_done_pulses", 64'(done_cnt), 64'd1);
    check("mult_done_at", 64'(done_at), 64'd33);

    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(3'd1, 32'd5, 32'hFFFF_FFFC, 40);
    check("mult_mixed", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEC);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 40);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 40);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op(3'd4, 32'd100, 32'd7, 40);
    check("divu_100_7", {hi, lo}, 64'h0000_0002_0000_000E);
    check("divu_div_zero_flag", {63'd0, dz_seen}, 64'd0);

    run_op(3'd4, 32'd5, 32'd0, 40);
    check("divu_zero_result", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
`ifdef MULDIV_DIVZERO_EN
    check("divz_done_at", 64'(done_at), 64'd1);
    check("divz_busy_cycles", 64'(busy_cnt), 64'd1);
    check("divz_flag", {63'd0, dz_seen}, 64'd1);
`else
    check("divz_done_at", 64'(done_at), 64'd33);
    check("divz_busy_cycles", 64'(busy_cnt), 64'd33);
    check("divz_flag", {63'd0, dz_seen}, 64'd0);
`endif

    // flush in CALC once the counter reaches 10; an MTHI during busy must be dropped
    @(negedge clk);
    start = 1'b1; op = 3'd1; x = 32'd3; y = 32'd9;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (done) done_cnt++;
      if (i == 5) begin
        start = 1'b1; op = 3'd5; x = 32'h0000_DEAD;
      end
      if (i == 21) begin
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
      end
      if (i == 22) check("flush_busy_after", {63'd0, busy}, 64'd0);
    end
    check("flush_no_done", 64'(done_cnt), 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

    // flush in IDLE wins over a simultaneous MTLO
    @(negedge clk);
    start = 1'b1; op = 3'd6; x = 32'h55; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_beats_start", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);

    // back-to-back moves
    @(negedge clk);
    start = 1'b1; op = 3'd5; x = 32'h1234;
    @(negedge clk);
    check("mthi_busy", {62'd0, busy, done}, 64'd0);
    op = 3'd6; x = 32'hABCD;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", {62'd0, busy, done}, 64'd0);
    check("mthi_mtlo", {hi, lo}, 64'h0000_1234_0000_ABCD);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd3; x = 32'd100; y = 32'd7;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_div_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {62'd0, busy, done}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
